// File: rtl/rans_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rans_stream_decoder
// Brief    : Framed rANS decoder; power-of-two table total, bit-serial binary
//            search symbol lookup, nibble-wise renormalisation.
// Revision : 1.0 - initial release
// ============================================================================
module rans_stream_decoder #(
    parameter int SYM_WIDTH   = 4,
    parameter int PROB_BITS   = 8,
    parameter int IN_WIDTH    = 4,
    parameter int STATE_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [(2**SYM_WIDTH)*(PROB_BITS+1)-1:0] freq_flat,
    input  logic [(2**SYM_WIDTH)*(PROB_BITS+1)-1:0] cum_flat,
    input  logic                                    start,
    input  logic [CNT_WIDTH-1:0]                    n_syms,
    input  logic [IN_WIDTH-1:0]                     in_data,
    input  logic                                    in_vld,
    output logic                                    in_rdy,
    output logic [SYM_WIDTH-1:0]                    out_data,
    output logic                                    out_last,
    output logic                                    out_vld,
    input  logic                                    out_rdy,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err
);

    localparam int c_sym_count  = 2**SYM_WIDTH;
    localparam int c_fw         = PROB_BITS + 1;
    localparam int c_load_words = STATE_WIDTH / IN_WIDTH;
    localparam int c_wc_w       = $clog2(c_load_words + 1);
    localparam int c_bit_w      = (SYM_WIDTH > 1) ? $clog2(SYM_WIDTH) : 1;
    localparam logic [STATE_WIDTH-1:0] c_x_low = STATE_WIDTH'(1) << (STATE_WIDTH - IN_WIDTH);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_lookup = 3'd2;
    localparam logic [2:0] c_st_emit   = 3'd3;
    localparam logic [2:0] c_st_renorm = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic [STATE_WIDTH-1:0] r_x;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   r_nsyms;
    logic [SYM_WIDTH-1:0]   r_sym;
    logic [c_bit_w-1:0]     r_bit;
    logic [c_wc_w-1:0]      r_wcnt;
    logic                   r_done;
    logic                   r_err;

    logic [c_fw-1:0] w_freq [c_sym_count];
    logic [c_fw-1:0] w_cum  [c_sym_count];

    for (genvar s = 0; s < c_sym_count; s++) begin : g_tab
        assign w_freq[s] = freq_flat[s*c_fw +: c_fw];
        assign w_cum[s]  = cum_flat[s*c_fw +: c_fw];
    end

    logic [PROB_BITS-1:0]   w_slot;
    logic [SYM_WIDTH-1:0]   w_cand;
    logic [SYM_WIDTH-1:0]   w_sym_next;
    logic                   w_lookup_last;
    logic                   w_zero_freq;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last_sym;
    logic                   w_x_small;
    logic [STATE_WIDTH-1:0] w_x_shift;
    logic [STATE_WIDTH-1:0] w_x_dec;

    assign w_slot        = r_x[PROB_BITS-1:0];
    // Bit-serial search: tentatively set the current bit, keep it if cum still fits under slot.
    assign w_cand        = r_sym | (SYM_WIDTH'(1) << r_bit);
    assign w_sym_next    = (w_cum[w_cand] <= {1'b0, w_slot}) ? w_cand : r_sym;
    assign w_lookup_last = (r_bit == '0);
    assign w_zero_freq   = (w_freq[w_sym_next] == '0);
    assign w_in_fire     = in_vld && in_rdy;
    assign w_out_fire    = out_vld && out_rdy;
    assign w_last_sym    = (r_count == (r_nsyms - CNT_WIDTH'(1)));
    assign w_x_small     = (r_x < c_x_low);
    assign w_x_shift     = {r_x[STATE_WIDTH-IN_WIDTH-1:0], in_data};
    assign w_x_dec       = STATE_WIDTH'(w_freq[r_sym]) * (r_x >> PROB_BITS)
                         + STATE_WIDTH'(w_slot) - STATE_WIDTH'(w_cum[r_sym]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (start && (n_syms != '0)) w_next_state = c_st_load;
            c_st_load:   if (w_in_fire && (r_wcnt == c_wc_w'(c_load_words - 1))) w_next_state = c_st_lookup;
            c_st_lookup: if (w_lookup_last) w_next_state = w_zero_freq ? c_st_idle : c_st_emit;
            c_st_emit:   if (w_out_fire) w_next_state = w_last_sym ? c_st_idle : c_st_renorm;
            c_st_renorm: if (!w_x_small) w_next_state = c_st_lookup;
            default:     w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        in_rdy   = 1'b0;
        out_vld  = 1'b0;
        out_last = 1'b0;
        busy     = (r_state != c_st_idle);
        case (r_state)
            c_st_load:   in_rdy = 1'b1;
            c_st_renorm: in_rdy = w_x_small;
            c_st_emit: begin
                out_vld  = 1'b1;
                out_last = w_last_sym;
            end
            default: ;
        endcase
    end

    assign out_data = r_sym;
    assign done     = r_done;
    assign err      = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_count <= '0;
            r_nsyms <= '0;
            r_sym   <= '0;
            r_bit   <= '0;
            r_wcnt  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_nsyms <= n_syms;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_x     <= '0;
                        r_wcnt  <= '0;
                        r_done  <= (n_syms == '0);
                    end
                end
                c_st_load: begin
                    if (w_in_fire) begin
                        r_x    <= w_x_shift;
                        r_wcnt <= r_wcnt + c_wc_w'(1);
                    end
                end
                c_st_lookup: begin
                    r_sym <= w_sym_next;
                    r_bit <= r_bit - c_bit_w'(1);
                    if (w_lookup_last && w_zero_freq) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                c_st_emit: begin
                    if (w_out_fire) begin
                        r_x     <= w_x_dec;
                        r_count <= r_count + CNT_WIDTH'(1);
                        r_done  <= w_last_sym;
                    end
                end
                c_st_renorm: begin
                    if (w_in_fire) r_x <= w_x_shift;
                end
                default: ;
            endcase
            // Every search begins from symbol 0 with the top bit under test.
            if ((r_state != c_st_lookup) && (w_next_state == c_st_lookup)) begin
                r_sym <= '0;
                r_bit <= c_bit_w'(SYM_WIDTH - 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rans_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rans_stream_decoder
// Brief    : Directed self-checking bench for rans_stream_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rans_stream_decoder;

    localparam int FW = 9;
    localparam int SC = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [SC*FW-1:0] freq_flat;
    logic [SC*FW-1:0] cum_flat;
    logic             start;
    logic [15:0]      n_syms;
    logic [3:0]       in_data;
    logic             in_vld;
    logic             in_rdy;
    logic [3:0]       out_data;
    logic             out_last;
    logic             out_vld;
    logic             out_rdy;
    logic             busy;
    logic             done;
    logic             err;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int word_cnt = 0;

    rans_stream_decoder dut (
        .clk(clk), .rst(rst), .freq_flat(freq_flat), .cum_flat(cum_flat),
        .start(start), .n_syms(n_syms), .in_data(in_data), .in_vld(in_vld),
        .in_rdy(in_rdy), .out_data(out_data), .out_last(out_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (in_vld && in_rdy) word_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_table(input int mode);
        int fr [4] = '{128, 64, 32, 32};
        int cu [4] = '{0, 128, 192, 224};
        for (int s = 0; s < SC; s++) begin
            if (mode == 2) begin
                freq_flat[s*FW +: FW] = (s < 4) ? 9'(fr[s]) : 9'd0;
                cum_flat[s*FW +: FW]  = (s < 4) ? 9'(cu[s]) : 9'd256;
            end else begin
                freq_flat[s*FW +: FW] = (mode == 1 && s == 5) ? 9'd0 : 9'd16;
                cum_flat[s*FW +: FW]  = 9'(16 * s);
            end
        end
    endtask

    task automatic start_frame(input int n);
        n_syms = 16'(n);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic feed_word(input logic [3:0] w, output bit ok);
        ok      = 1'b0;
        in_data = w;
        in_vld  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_rdy) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_vld = 1'b0;
    endtask

    task automatic recv_sym(output logic [3:0] d, output logic l, output bit ok);
        ok      = 1'b0;
        d       = 4'hx;
        l       = 1'bx;
        out_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (out_vld) begin
                d = out_data;
                l = out_last;
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        out_rdy = 1'b0;
    endtask

    // Two-symbol uniform frame: words 1,2,3,4 then 5 should give symbols 3 then 4(last).
    task automatic basic_frame(output logic [3:0] s0, output logic l0,
                               output logic [3:0] s1, output logic l1,
                               output int words, output bit ok);
        bit o;
        int w0;
        ok = 1'b1;
        w0 = word_cnt;
        start_frame(2);
        for (int k = 1; k <= 4; k++) begin
            feed_word(4'(k), o);
            ok &= o;
        end
        recv_sym(s0, l0, o); ok &= o;
        feed_word(4'd5, o);  ok &= o;
        recv_sym(s1, l1, o); ok &= o;
        words = word_cnt - w0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if ({in_rdy, out_vld, out_last, busy, done, err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {in_rdy, out_vld, out_last, busy, done, err});
        end
        n_cmp++; if (out_data !== 4'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", out_data);
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_uniform();
        logic [3:0] s0, s1;
        logic l0, l1;
        int words;
        bit ok;
        set_table(0);
        basic_frame(s0, l0, s1, l1, words, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL uni_handshake: timeout"); end
        n_cmp++; if ({s0, l0} !== {4'd3, 1'b0}) begin n_fail++; $display("FAIL uni_sym0: got %h/%b want 3/0", s0, l0); end
        n_cmp++; if ({s1, l1} !== {4'd4, 1'b1}) begin n_fail++; $display("FAIL uni_sym1: got %h/%b want 4/1", s1, l1); end
        n_cmp++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL uni_done: done/busy=%b want 10", {done, busy}); end
        n_cmp++; if (words !== 5) begin n_fail++; $display("FAIL uni_words: got %0d want 5", words); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL uni_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_skewed();
        int seq [20] = '{0, 1, 0, 2, 3, 0, 0, 1, 3, 2, 0, 1, 0, 0, 2, 3, 1, 0, 0, 3};
        int unsigned fr [4] = '{128, 64, 32, 32};
        int unsigned cu [4] = '{0, 128, 192, 224};
        int unsigned x;
        int q [$];
        int st [$];
        int w0;
        bit feed_ok, sym_ok;
        set_table(2);
        // Reference rANS encoder, symbols processed last to first.
        x = 4096;
        for (int i = 19; i >= 0; i--) begin
            int unsigned f;
            f = fr[seq[i]];
            while (x >= 256 * f) begin
                if (i != 19) q.push_back(int'(x & 15));
                x = x >> 4;
            end
            x = ((x / f) << 8) + (x % f) + cu[seq[i]];
        end
        for (int k = 3; k >= 0; k--) st.push_back(int'((x >> (4 * k)) & 15));
        for (int k = q.size() - 1; k >= 0; k--) st.push_back(q[k]);
        w0 = word_cnt;
        feed_ok = 1'b1;
        sym_ok  = 1'b1;
        start_frame(20);
        fork
            begin
                bit o;
                for (int k = 0; k < st.size(); k++) begin
                    feed_word(4'(st[k]), o);
                    feed_ok &= o;
                end
            end
            begin
                logic [3:0] d;
                logic l;
                bit o;
                for (int i = 0; i < 20; i++) begin
                    recv_sym(d, l, o);
                    sym_ok &= o;
                    n_cmp++; if ({d, l} !== {4'(seq[i]), (i == 19)}) begin
                        n_fail++; $display("FAIL skew_sym%0d: got %h/%b want %h/%b", i, d, l, 4'(seq[i]), (i == 19));
                    end
                end
            end
        join
        n_cmp++; if ({feed_ok, sym_ok} !== 2'b11) begin n_fail++; $display("FAIL skew_handshake: feed/recv ok=%b want 11", {feed_ok, sym_ok}); end
        n_cmp++; if (word_cnt - w0 !== st.size()) begin
            n_fail++; $display("FAIL skew_words: got %0d want %0d", word_cnt - w0, st.size());
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL skew_done: done=%b want 1", done); end
        tick();
    endtask

    task automatic test_stall();
        logic [3:0] d;
        logic l;
        bit ok, o;
        set_table(0);
        ok = 1'b1;
        start_frame(2);
        for (int k = 1; k <= 4; k++) begin
            feed_word(4'(k), o);
            ok &= o;
        end
        o = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_vld) begin o = 1'b1; break; end
            tick();
        end
        ok &= o;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++; if ({out_vld, out_data, out_last, in_rdy} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL stall_c%0d: vld/data/last/in_rdy=%b/%h/%b/%b want 1/3/0/0", c, out_vld, out_data, out_last, in_rdy);
            end
        end
        recv_sym(d, l, o); ok &= o;
        n_cmp++; if ({d, l} !== {4'd3, 1'b0}) begin n_fail++; $display("FAIL stall_sym0: got %h/%b want 3/0", d, l); end
        feed_word(4'd5, o); ok &= o;
        recv_sym(d, l, o); ok &= o;
        n_cmp++; if ({d, l} !== {4'd4, 1'b1}) begin n_fail++; $display("FAIL stall_sym1: got %h/%b want 4/1", d, l); end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_handshake: timeout"); end
        tick();
    endtask

    task automatic test_zero_freq();
        logic [3:0] s0, s1;
        logic l0, l1;
        int words, d0;
        bit ok, o, seen_vld;
        set_table(1);
        ok = 1'b1;
        seen_vld = 1'b0;
        d0 = done_cnt;
        start_frame(2);
        feed_word(4'd1, o); ok &= o;
        feed_word(4'd2, o); ok &= o;
        feed_word(4'd5, o); ok &= o;
        feed_word(4'd0, o); ok &= o;
        o = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_vld) seen_vld = 1'b1;
            if (!busy) begin o = 1'b1; break; end
            tick();
        end
        ok &= o;
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL zf_handshake: timeout"); end
        n_cmp++; if ({err, seen_vld, in_rdy} !== 3'b100) begin
            n_fail++; $display("FAIL zf_err: err/out_vld/in_rdy=%b want 100", {err, seen_vld, in_rdy});
        end
        tick();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL zf_done: pulses=%0d want 1", done_cnt - d0); end
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL zf_sticky: err=%b want 1", err); end
        set_table(0);
        basic_frame(s0, l0, s1, l1, words, ok);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL zf_err_clear: err=%b want 0", err); end
        n_cmp++; if ({ok, s0, l0, s1, l1} !== {1'b1, 4'd3, 1'b0, 4'd4, 1'b1}) begin
            n_fail++; $display("FAIL zf_recover: ok/s0/l0/s1/l1=%b/%h/%b/%h/%b want 1/3/0/4/1", ok, s0, l0, s1, l1);
        end
        tick();
    endtask

    task automatic test_empty_and_busy_start();
        logic [3:0] d;
        logic l;
        int d0;
        bit ok, o;
        set_table(0);
        d0 = done_cnt;
        start_frame(0);
        n_cmp++; if ({done, busy, in_rdy} !== 3'b100) begin
            n_fail++; $display("FAIL empty_done: done/busy/in_rdy=%b want 100", {done, busy, in_rdy});
        end
        tick();
        n_cmp++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL empty_pulse: done/busy=%b want 00", {done, busy}); end
        ok = 1'b1;
        start_frame(2);
        feed_word(4'd1, o); ok &= o;
        feed_word(4'd2, o); ok &= o;
        start_frame(2);
        n_cmp++; if ({busy, in_rdy} !== 2'b11) begin n_fail++; $display("FAIL busy_start: busy/in_rdy=%b want 11", {busy, in_rdy}); end
        feed_word(4'd3, o); ok &= o;
        feed_word(4'd4, o); ok &= o;
        recv_sym(d, l, o); ok &= o;
        n_cmp++; if ({d, l} !== {4'd3, 1'b0}) begin n_fail++; $display("FAIL busy_sym0: got %h/%b want 3/0", d, l); end
        feed_word(4'd5, o); ok &= o;
        recv_sym(d, l, o); ok &= o;
        n_cmp++; if ({ok, d, l} !== {1'b1, 4'd4, 1'b1}) begin n_fail++; $display("FAIL busy_sym1: ok/d/l=%b/%h/%b want 1/4/1", ok, d, l); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
        tick();
    endtask

    task automatic test_rst_renorm();
        logic [3:0] s0, s1;
        logic l0, l1;
        int words, d0;
        bit ok, o;
        set_table(0);
        ok = 1'b1;
        start_frame(2);
        for (int k = 1; k <= 4; k++) begin
            feed_word(4'(k), o);
            ok &= o;
        end
        recv_sym(s0, l0, o); ok &= o;
        n_cmp++; if ({ok, in_rdy, busy} !== 3'b111) begin
            n_fail++; $display("FAIL rst_pre: ok/in_rdy/busy=%b want 111", {ok, in_rdy, busy});
        end
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        n_cmp++; if ({in_rdy, out_vld, out_last, busy, done, err, out_data} !== 10'b0) begin
            n_fail++; $display("FAIL rst_mid: got %b want 0000000000", {in_rdy, out_vld, out_last, busy, done, err, out_data});
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rst_no_done: pulses=%0d want 0", done_cnt - d0); end
        basic_frame(s0, l0, s1, l1, words, ok);
        n_cmp++; if ({ok, s0, l0, s1, l1, words} !== {1'b1, 4'd3, 1'b0, 4'd4, 1'b1, 32'd5}) begin
            n_fail++; $display("FAIL rst_recover: ok/s0/l0/s1/l1/words=%b/%h/%b/%h/%b/%0d want 1/3/0/4/1/5", ok, s0, l0, s1, l1, words);
        end
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        n_syms  = '0;
        in_data = '0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        set_table(0);
        test_reset();
        test_uniform();
        test_skewed();
        test_stall();
        test_zero_freq();
        test_empty_and_busy_start();
        test_rst_renorm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
